// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one GCD core among N_REQ requesters.
// Zero operands are answered locally without touching the core.
module gcd_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_grant,
    input  logic                   core_input_available,
    output logic                   core_input_ready,
    output logic [WIDTH-1:0]       core_operand_A,
    output logic [WIDTH-1:0]       core_operand_B,
    input  logic                   core_result_rdy,
    input  logic [WIDTH-1:0]       core_result_data,
    output logic                   core_result_taken,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    input  logic                   rsp_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_core_start;
    logic             r_rsp_valid;
    logic             r_bypass;

    logic             w_any;
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_next_ptr;
    logic             w_grant_en;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_bypass;
    logic [WIDTH-1:0] w_byp_res;

    // First asserted requester at or after r_rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!w_any && req_valid[idx]) begin
                w_any = 1'b1;
                w_win = IDW'(idx);
            end
        end
    end

    assign w_next_ptr = (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
    assign w_a        = req_a[int'(w_win)*WIDTH +: WIDTH];
    assign w_b        = req_b[int'(w_win)*WIDTH +: WIDTH];
    assign w_bypass   = (w_a == '0) || (w_b == '0);
    assign w_byp_res  = (w_a == '0) ? w_b : w_a;
    assign w_grant_en = (r_state == IDLE) && core_input_available && w_any && !sys_rst;

    assign req_grant         = w_grant_en ? (N_REQ'(1) << w_win) : '0;
    assign core_result_taken = (r_state == RESP) && rsp_ready && !r_bypass && !sys_rst;
    assign core_input_ready  = r_core_start;
    assign core_operand_A    = r_op_a;
    assign core_operand_B    = r_op_b;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_id            = r_id;
    assign rsp_data          = r_rsp_data;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_rsp_data   <= '0;
            r_core_start <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_bypass     <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_en) begin
                        r_id     <= w_win;
                        r_rr_ptr <= w_next_ptr;
                        r_bypass <= w_bypass;
                        if (w_bypass) begin
                            r_rsp_data  <= w_byp_res;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_op_a       <= w_a;
                            r_op_b       <= w_b;
                            r_core_start <= 1'b1;
                            r_state      <= ISSUE;
                        end
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (core_result_rdy) begin
                        r_rsp_data  <= core_result_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 Parameter N_REQ, default 4, number of requesters; IDW = clog2(N_REQ), minimum 1.
REQ-003 sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 sys_rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  N_REQ  per-requester request; held until granted.
REQ-006 req_a  in  N_REQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH].
REQ-007 req_b  in  N_REQ*WIDTH  packed operand B; same packing as req_a.
REQ-008 req_grant  out  N_REQ  one-hot, one-cycle pulse; operands taken on that cycle.
REQ-009 core_input_available  in  1  GCD core is idle and accepts operands.
REQ-010 core_input_ready  out  1  one-cycle start pulse to the core.
REQ-011 core_operand_A / core_operand_B  out  WIDTH each  operands to the core.
REQ-012 core_result_rdy  in  1  core result valid; level, held until taken.
REQ-013 core_result_data  in  WIDTH  core result.
REQ-014 core_result_taken  out  1  one-cycle pulse that releases the core result.
REQ-015 rsp_valid  out  1  response valid.
REQ-016 rsp_id  out  IDW  index of the requester the response belongs to.
REQ-017 rsp_data  out  WIDTH  GCD result.
REQ-018 rsp_ready  in  1  consumer accepts the response.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-020 IDLE, when core_input_available=1 and any req_valid=1:
- select the first asserted requester, scanning from rr_ptr upward with modulo-N_REQ wrap;
- pulse its req_grant bit;
- latch its operands and index;
- set rr_ptr = (winner+1) mod N_REQ;
- go to ISSUE.
REQ-021 Zero bypass: if a latched operand is 0 at grant time, result = the other operand (gcd(0,0)=0).
- Go directly IDLE->RESP, issuing nothing to the core.
- Core pulses (core_input_ready, core_result_taken) stay 0 for the whole transaction.
REQ-022 Zero-bypass grants are still subject to core_input_available=1.
REQ-023 ISSUE: core_input_ready=1 for exactly one cycle, then go to WAIT; latency is exactly 1 cycle from the grant to core_input_ready.
REQ-024 core_operand_A/B hold the latched operands from ISSUE until the WAIT->RESP transition.
REQ-025 WAIT: on core_result_rdy=1, capture core_result_data into rsp_data and go to RESP.
- No timeout.
- core_result_rdy seen in any other state is ignored.
REQ-026 RESP: rsp_valid=1, with rsp_id/rsp_data stable, until rsp_ready=1.
REQ-027 On the rsp_ready=1 cycle in RESP:
- pulse core_result_taken for that one cycle (core path only);
- go to IDLE, so rsp_valid=0 the next cycle.
REQ-028 No new grant in the cycle RESP exits; the earliest next grant is the first IDLE cycle.
REQ-029 Requests arriving in any state other than IDLE wait; req_valid deasserted before grant is simply dropped.
REQ-030 Simultaneous requests: exactly one grant per transaction, round-robin fair; no requester is starved while it holds req_valid.

Reset
REQ-031 On sys_rst=1 at a rising edge:
- state=IDLE, rr_ptr=0;
- req_grant, core_input_ready, core_result_taken, rsp_valid = 0;
- rsp_id, rsp_data, core_operand_A/B = 0.
REQ-032 Reset mid-operation abandons the in-flight transaction with no response and no core_result_taken; recovering the core is the system reset's job.
REQ-033 Reset has priority over all other inputs in the same cycle.

Verification
REQ-034 req0 (24,18), core available, rsp_ready=1 -> req_grant=0001, core_input_ready 1 cycle later, rsp_id=0, rsp_data=6, one core_result_taken pulse.
REQ-035 req0 (105,99) and req2 (12,66) together, rr_ptr=0 -> grant req0, response 3; then grant req2, response 6; rr_ptr ends at 3.
REQ-036 req1 (0,12) -> rsp_id=1, rsp_data=12; core_input_ready and core_result_taken never pulse. req3 (0,0) -> rsp_data=0.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_id/rsp_data stable all 5 cycles; core_result_taken only on the accepting cycle; no new grant meanwhile.
REQ-038 All four requesters held continuously -> grant order 0,1,2,3,0 with wrap-around; each responds with the correct GCD of its operands.
REQ-039 sys_rst pulsed during WAIT -> next cycle all outputs are 0 and state is IDLE; a later request is granted starting from requester 0.
